// File: rtl/result_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle) with a
// ready/valid handshake on both sides. Define BCD_SIGNED_EN for two's-complement operands.
module result_bcd_converter #(
  parameter int NUM_BITS   = 32,
  parameter int NUM_DIGITS = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_BITS-1:0]     sum,
  input  logic                    c_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    overflow,
  output logic                    negative
);

  localparam int CNT_W = $clog2(NUM_BITS + 1);
  localparam int BCD_W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [NUM_BITS-1:0] shift_reg;
  logic [NUM_BITS-1:0] operand_mag;
  logic [BCD_W-1:0]    scratch, scratch_adj, scratch_shifted;
  logic                overflow_next;
  logic                last_step;
  logic                accept;

  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

`ifdef BCD_SIGNED_EN
  logic negative_next;

  // The most-negative input negates to itself, which read unsigned is 2^(NUM_BITS-1).
  function automatic logic [NUM_BITS-1:0] magnitude(input logic [NUM_BITS-1:0] s);
    return s[NUM_BITS-1] ? (~s + NUM_BITS'(1)) : s;
  endfunction

  assign operand_mag = magnitude(sum);
`else
  assign operand_mag = sum;
  assign negative    = 1'b0;
`endif

  assign scratch_adj     = dabble_adjust(scratch);
  assign scratch_shifted = {scratch_adj[BCD_W-2:0], shift_reg[NUM_BITS-1]};
  assign last_step       = (cnt == CNT_W'(1));
  assign accept          = (state == IDLE) && in_valid;
  assign in_ready        = (state == IDLE);
  assign out_valid       = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = CONVERT;
      CONVERT: if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Conversion datapath; results only move to the outputs on the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      shift_reg     <= '0;
      scratch       <= '0;
      overflow_next <= 1'b0;
      bcd           <= '0;
      overflow      <= 1'b0;
`ifdef BCD_SIGNED_EN
      negative_next <= 1'b0;
      negative      <= 1'b0;
`endif
    end else if (accept) begin
      cnt           <= CNT_W'(NUM_BITS);
      shift_reg     <= operand_mag;
      scratch       <= '0;
      overflow_next <= c_out;
`ifdef BCD_SIGNED_EN
      negative_next <= sum[NUM_BITS-1];
`endif
    end else if (state == CONVERT) begin
      cnt       <= cnt - CNT_W'(1);
      shift_reg <= {shift_reg[NUM_BITS-2:0], 1'b0};
      scratch   <= scratch_shifted;
      if (last_step) begin
        bcd      <= scratch_shifted;
        overflow <= overflow_next;
`ifdef BCD_SIGNED_EN
        negative <= negative_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Bench for result_bcd_converter: table vectors, handshake/reset corner cases and
// random operands against a decimal-arithmetic reference model.
module tb_result_bcd_converter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] sum;
  logic        c_out;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] bcd;
  logic        overflow;
  logic        negative;

  int total = 0;
  int bad   = 0;

  result_bcd_converter #(.NUM_BITS(32), .NUM_DIGITS(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .c_out(c_out), .out_valid(out_valid), .out_ready(out_ready),
    .bcd(bcd), .overflow(overflow), .negative(negative)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic [39:0] exp_bcd;
    logic        exp_neg;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: magnitude by integer arithmetic, digits by repeated division by ten.
  function automatic logic [39:0] model_bcd(input logic [31:0] s, output logic neg);
    longint unsigned mag;
    logic [39:0] r;
    mag = 64'(s);
    neg = 1'b0;
`ifdef BCD_SIGNED_EN
    if (s >= 32'h8000_0000) begin
      mag = 64'h1_0000_0000 - 64'(s);
      neg = 1'b1;
    end
`endif
    r = '0;
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return r;
  endfunction

  // Accepts one operand, waits for out_valid, checks latency, result and retention.
  task automatic convert(input string name, input logic [31:0] s, input logic co,
                         input logic consume);
    logic [39:0] prev_bcd, exp_b;
    logic        exp_n;
    int          lat;
    prev_bcd = bcd;
    exp_b    = model_bcd(s, exp_n);
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    sum = s; c_out = co; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; sum = $urandom; c_out = $urandom_range(1);
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (lat == 3) check({name, "_bcd_held"}, 64'(bcd), 64'(prev_bcd));
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'd32);
    check({name, "_bcd"}, 64'(bcd), 64'(exp_b));
    check({name, "_ovf"}, 64'(overflow), 64'(co));
    check({name, "_neg"}, 64'(negative), 64'(exp_n));
    if (consume) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({name, "_back_idle"}, 64'({in_ready, out_valid}), 64'b10);
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic [39:0] held, exp_b;
    logic        exp_n;

    rst_n = 1'b0; in_valid = 1'b0; sum = '0; c_out = 1'b0; out_ready = 1'b0;
    #3;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_outputs", 64'({bcd, overflow, negative}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    vecs.push_back('{32'h0000_3039, 1'b0, 40'h00_0001_2345, 1'b0});
    vecs.push_back('{32'h0000_0000, 1'b1, 40'h00_0000_0000, 1'b0});
    vecs.push_back('{32'h0000_0000, 1'b0, 40'h00_0000_0000, 1'b0});
    vecs.push_back('{32'h0000_0007, 1'b0, 40'h00_0000_0007, 1'b0});
    vecs.push_back('{32'h05F5_E0FF, 1'b1, 40'h00_9999_9999, 1'b0});
    vecs.push_back('{32'h3B9A_CA00, 1'b0, 40'h10_0000_0000, 1'b0});
    vecs.push_back('{32'h7FFF_FFFF, 1'b0, 40'h21_4748_3647, 1'b0});
`ifdef BCD_SIGNED_EN
    vecs.push_back('{32'hFFFF_FFFF, 1'b1, 40'h00_0000_0001, 1'b1});
    vecs.push_back('{32'h8000_0000, 1'b0, 40'h21_4748_3648, 1'b1});
`else
    vecs.push_back('{32'hFFFF_FFFF, 1'b1, 40'h42_9496_7295, 1'b0});
    vecs.push_back('{32'h8000_0000, 1'b0, 40'h21_4748_3648, 1'b0});
`endif

    // Table vectors: constants checked directly, then full handshake via convert().
    foreach (vecs[i]) begin
      check($sformatf("tbl%0d_model", i), 64'(model_bcd(vecs[i].s, exp_n)), 64'(vecs[i].exp_bcd));
      convert($sformatf("tbl%0d", i), vecs[i].s, vecs[i].co, 1'b1);
      check($sformatf("tbl%0d_const", i), 64'({bcd, negative}), 64'({vecs[i].exp_bcd, vecs[i].exp_neg}));
    end

    // Stall in DONE while upstream offers a new operand.
    convert("stall", 32'd123456789, 1'b0, 1'b0);
    held = bcd;
    in_valid = 1'b1; sum = 32'd4096; c_out = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("stall_hold%0d", i), 64'({bcd, in_ready, out_valid}), 64'({held, 1'b0, 1'b1}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall_release", 64'({in_ready, out_valid}), 64'b10);
    convert("stall_next", 32'd4096, 1'b1, 1'b1);

    // Reset in the middle of a conversion.
    sum = 32'd987654; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_outputs", 64'({bcd, overflow, negative, out_valid}), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    convert("after_rst", 32'd7, 1'b0, 1'b1);
    check("after_rst_val", 64'(bcd), 64'h7);

    // Random operands against the model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] r;
      r = (i % 4 == 0) ? ($urandom & 32'h0000_FFFF) : $urandom;
      convert($sformatf("rnd%0d", i), r, 1'($urandom_range(1)), 1'b1);
    end

    exp_b = model_bcd(32'd0, exp_n);
    check("zero_model", 64'({exp_b, exp_n}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
